// File: rtl/shift_req_queue.sv
// ---------------------------------------------------------------------------
// shift_req_queue
//
// Request-buffering stage in front of an external 8-bit combinational
// shifter. Shift requests (op code + operand) arrive over a valid/ready
// handshake and wait in a DEPTH-entry FIFO. The head entry drives the
// shifter's inputs. The shifter's result is captured into a valid/ready
// output register, which gives the consumer a pipelined service that it
// can hold off with back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   queue can accept (not full)
//   in_type    requested op code
//   in_num     operand
//   sh_type    to shifter shiftType: head-entry op (0 when empty)
//   sh_num     to shifter num: head-entry operand (0 when empty)
//   sh_result  from shifter out (combinational in sh_type/sh_num)
//   out_valid  result register holds a valid result
//   out_ready  consumer accepts the result
//   out_type   op code that produced out_result
//   out_result registered shift result
//   count      current FIFO occupancy (excludes the output register)
// ---------------------------------------------------------------------------
module shift_req_queue #(
    parameter int DEPTH = 4,
    parameter int OPW   = 3,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_type,
    input  logic [DW-1:0]            in_num,
    output logic [OPW-1:0]           sh_type,
    output logic [DW-1:0]            sh_num,
    input  logic [DW-1:0]            sh_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPW-1:0]           out_type,
    output logic [DW-1:0]            out_result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    // FIFO storage: op code and operand kept side by side per entry.
    logic [OPW-1:0] type_mem [DEPTH];
    logic [DW-1:0]  num_mem  [DEPTH];

    // DEPTH is a power of two, so the pointers wrap naturally.
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    logic           empty;
    logic           push;
    logic           load;

    assign empty    = (count == '0);

    // in_ready depends only on the registered count: a full queue refuses
    // a push even in a cycle where it also pops.
    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready;

    // Head moves into the output register whenever there is something to
    // move and the register is free or is being emptied this cycle.
    assign load     = !empty && (!out_valid || out_ready);

    // Head entry to the shifter. Forced to zero when empty so that stale
    // storage never shows up on the shifter inputs.
    always_comb begin
        sh_type = '0;
        sh_num  = '0;
        if (!empty) begin
            sh_type = type_mem[rd_ptr];
            sh_num  = num_mem[rd_ptr];
        end
    end

    // Storage has no reset: its contents are only ever read below count.
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr] <= in_type;
            num_mem[wr_ptr]  <= in_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register. When it drains with nothing queued behind it, only
    // the valid flag drops; type and result keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_type   <= '0;
            out_result <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_type   <= sh_type;
            out_result <= sh_result;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_req_queue.sv
// ---------------------------------------------------------------------------
// tb_shift_req_queue
//
// Bench for shift_req_queue. A behavioural stand-in for the 8-bit shifter
// (shift amount 3) is connected to sh_type/sh_num/sh_result. Each accepted request
// pushes its expected {op, result} onto a scoreboard queue. A separate
// monitor pops and compares whenever a result is handed off. The monitor also
// checks that a stalled result holds stable.
// ---------------------------------------------------------------------------
module tb_shift_req_queue;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_type;
    logic [7:0] in_num;
    logic [2:0] sh_type;
    logic [7:0] sh_num;
    logic [7:0] sh_result;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_type;
    logic [7:0] out_result;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];

    logic       hold;
    logic [2:0] hold_type;
    logic [7:0] hold_res;

    shift_req_queue #(.DEPTH(4), .OPW(3), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_num     (in_num),
        .sh_type    (sh_type),
        .sh_num     (sh_num),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_result (out_result),
        .count      (count)
    );

    // Shifter behaviour, k = 3.
    function automatic logic [7:0] shf(input logic [2:0] t, input logic [7:0] n);
        case (t)
            3'd0, 3'd2: shf = n >> 3;
            3'd1, 3'd3: shf = n << 3;
            3'd4:       shf = {n[2:0], n[7:3]};
            3'd5:       shf = {n[4:0], n[7:5]};
            default:    shf = 8'h00;
        endcase
    endfunction

    assign sh_result = shf(sh_type, sh_num);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, then note whether
    // the request will be accepted at the next rising edge.
    task automatic drive(input logic v, input logic [2:0] t, input logic [7:0] n, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_type   = t;
        in_num    = n;
        out_ready = r;
        #1;
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back({in_type, shf(in_type, in_num)});
            $display("push  type=%0d num=0x%02h count=%0d", in_type, in_num, count);
        end
    endtask

    // Monitor: runs after the driver has settled each cycle.
    initial begin
        logic [10:0] e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!out_valid || out_type != hold_type || out_result != hold_res) begin
                        errors++;
                        $display("FAIL hold: got v=%0d type=%0d res=0x%02h expected v=1 type=%0d res=0x%02h",
                                 out_valid, out_type, out_result, hold_type, hold_res);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got type=%0d res=0x%02h expected none",
                                 out_type, out_result);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_type, out_result} != e) begin
                            errors++;
                            $display("FAIL result: got type=%0d res=0x%02h expected type=%0d res=0x%02h",
                                     out_type, out_result, e[10:8], e[7:0]);
                        end else begin
                            $display("pop   type=%0d res=0x%02h", out_type, out_result);
                        end
                    end
                end
                hold      = out_valid && !out_ready;
                hold_type = out_type;
                hold_res  = out_result;
            end
        end
    end

    initial begin
        logic [7:0] tbl [6];
        tbl = '{8'h10, 8'h08, 8'h10, 8'h08, 8'h30, 8'h0C};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_type   = '0;
        in_num    = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_type", out_type, 0);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sh_num", sh_num, 0);

        // Single request, latency
        drive(1'b1, 3'd0, 8'hB4, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 1'b1);
        chk("lat_not_yet_valid", out_valid, 0);
        chk("lat_count1", count, 1);
        drive(1'b0, 3'd0, 8'h00, 1'b1);
        chk("lat_valid", out_valid, 1);
        chk("lat_type", out_type, 0);
        chk("lat_result", out_result, 8'h16);
        chk("lat_count0", count, 0);
        drive(1'b0, 3'd0, 8'h00, 1'b1);

        // Back-to-back stream, one result per cycle
        for (int j = 0; j < 8; j++) begin
            drive(j < 6, 3'(j), 8'h81, 1'b1);
            if (j >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_result", out_result, tbl[j-2]);
            end
        end
        repeat (2) drive(1'b0, 3'd0, 8'h00, 1'b1);

        // Fill with back-pressure, refused push while full, pop-on-full
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 3'(j), 8'($urandom), 1'b0);
        end
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        drive(1'b1, 3'd6, 8'h55, 1'b1);
        chk("full_pop_refused_ready", in_ready, 0);
        drive(1'b1, 3'd7, 8'hAA, 1'b1);
        chk("after_pop_count", count, 3);
        chk("after_pop_in_ready", in_ready, 1);
        repeat (10) drive(1'b0, 3'd0, 8'h00, 1'b1);
        chk("full_drained", exp_q.size(), 0);
        chk("full_drained_count", count, 0);

        // Random traffic with random back-pressure
        for (int j = 0; j < 500; j++) begin
            drive(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
            checks++;
            if (count > 4 || in_ready != (count != 3'd4)) begin
                errors++;
                $display("FAIL occupancy: got count=%0d in_ready=%0d expected count<=4 in_ready=(count!=4)",
                         count, in_ready);
            end
        end
        repeat (12) drive(1'b0, 3'd0, 8'h00, 1'b1);
        chk("rand_drained", exp_q.size(), 0);

        // Asynchronous reset mid-stream
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 3'(j + 1), 8'($urandom), 1'b0);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_type", out_type, 0);
        chk("arst_count", count, 0);
        exp_q.delete();
        hold = 1'b0;
        repeat (2) drive(1'b0, 3'd0, 8'h00, 1'b1);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (5) drive(1'b0, 3'd0, 8'h00, 1'b1);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_req_queue.md
Name: shift_req_queue

Overview:
- Request-buffering stage wrapped around the 8-bit combinational shifter.
- Accepts shift requests (3-bit op code plus 8-bit operand) over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Presents the head entry to the shifter's shiftType/num inputs and registers the shifter's result into a valid/ready output stage, giving downstream logic a pipelined, back-pressurable shift service.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- OPW, 3, op-code width; matches the shifter shiftType.
- DW, 8, operand/result width; matches the shifter num/out.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  queue can accept; equals !full.
- in_type  input  OPW  requested op code.
- in_num  input  DW  operand.
- sh_type  output  OPW  to shifter shiftType; head-entry op.
- sh_num  output  DW  to shifter num; head-entry operand.
- sh_result  input  DW  from shifter out; combinational function of sh_type/sh_num.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_type  output  OPW  op code that produced out_result.
- out_result  output  DW  registered shift result.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): write and read pointers 0, count 0, out_valid 0, out_type 0, out_result 0. in_ready reads 1 once reset is released. FIFO storage contents are don't-care.
- Reset asserted mid-operation discards all queued entries and any pending result, with no partial outputs.
- Push: on in_valid && in_ready at a clock edge, {in_type, in_num} is written at the write pointer. The write pointer wraps modulo DEPTH.
- Full: count == DEPTH gives in_ready 0. A push is refused while full even if a pop occurs in the same cycle; in_ready depends only on registered count.
- Head: sh_type/sh_num are driven combinationally from the entry at the read pointer. They are 0 when empty.
- Load condition: load = (count != 0) && (!out_valid || out_ready).
- On load at an edge: out_result <= sh_result, out_type <= head op, out_valid <= 1, the entry pops, and the read pointer wraps modulo DEPTH.
- out_valid && out_ready with count == 0: out_valid <= 0 and out_result/out_type hold their values.
- out_valid && !out_ready: out_valid, out_type and out_result hold stable. No pop occurs.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- count never exceeds DEPTH and never underflows.
- Latency: a request pushed at edge N into an empty queue produces out_valid=1 after edge N+1. Minimum latency is 1 cycle from acceptance to result.
- Throughput: 1 result/cycle with out_ready held high.
- Ordering: strict FIFO. Results leave in acceptance order.
- Op codes are opaque here. Op 110/111 pass through, and the result is whatever sh_result returns (0 from the shifter).

Test Plan:
- Reset, then push type=000 num=0xB4 once, out_ready=1 -> out_valid high one edge after acceptance, out_type=000, out_result=0x16; count returns to 0.
- Hold out_ready=0, push 5 requests with DEPTH=4 -> first is captured in the output register, next 4 fill the FIFO (count=4, in_ready=0), 6th push refused; release out_ready -> 5 results in order, none lost or duplicated.
- Continuous stream of ops 000..101 on num=0x81, out_ready=1 -> one result per cycle: 0x10, 0x08, 0x10, 0x08, 0x30, 0x0C (per shifter behaviour, k=3), in order.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> one pop, push refused that cycle, count drops to DEPTH-1, next cycle push accepted.
- Random out_ready toggling -> out_result/out_type stable whenever out_valid && !out_ready; pointers wrap at least 3 times with data intact.
- Assert rst_n low mid-stream with count=3 and out_valid=1 -> outputs go to 0 immediately without a clock, count=0, and no stale result appears after release.
